// File: rtl/gauss_out_fifo.sv
// Output FIFO for the Box-Muller generator: buffers (in1,in2) pairs and serialises them
// onto one valid/ready word stream. Define GAUSS_DROP_CNT_EN to build the dropped-pair counter.
module gauss_out_fifo #(
    parameter int OUT    = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int WARMUP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OUT-1:0] in1,
    input  logic [OUT-1:0] in2,
    input  logic           in_en,
    output logic [OUT-1:0] dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [AW:0]    level,
    output logic           full,
    output logic           empty,
    output logic           overflow,
    output logic [15:0]    drop_cnt
);

    localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         warm_cnt;
    logic                  warm;
    logic [2*OUT-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           level_q;
    logic [OUT-1:0]        hold1, hold2;
    logic                  wr, drop, pop;

    // Generator output is garbage until its pipeline has filled.
    assign warm = (warm_cnt == CW'(WARMUP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        warm_cnt <= '0;
        else if (!warm) warm_cnt <= warm_cnt + 1'b1;
    end

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign wr    = warm && in_en && !full;
    assign drop  = warm && in_en && full;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {in1, in2};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold1 <= '0;
            hold2 <= '0;
        end else begin
            state <= state_nx;
            if (pop) {hold1, hold2} <= mem[rd_ptr];
        end
    end

    // Popping in SEND2 on the final handshake keeps pairs back-to-back.
    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        dout       = '0;
        dout_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = SEND1;
                end
            end
            SEND1: begin
                dout       = hold1;
                dout_valid = 1'b1;
                if (dout_ready) state_nx = SEND2;
            end
            SEND2: begin
                dout       = hold2;
                dout_valid = 1'b1;
                if (dout_ready) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = SEND1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef GAUSS_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             drop_q <= '0;
        else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gauss_out_fifo.sv
// Randomised bench for gauss_out_fifo against a queue-based reference of the pair buffer.
module tb_gauss_out_fifo;
    localparam int OUT = 32, DEPTH = 16, AW = 4, WARMUP = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [OUT-1:0] in1 = '0, in2 = '0;
    logic           in_en = 1'b0;
    logic [OUT-1:0] dout;
    logic           dout_valid;
    logic           dout_ready = 1'b0;
    logic [AW:0]    level;
    logic           full, empty, overflow;
    logic [15:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    gauss_out_fifo #(.OUT(OUT), .DEPTH(DEPTH), .AW(AW), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in_en(in_en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference: queue of stored pairs, one holding slot with words remaining, warm-up count.
    logic [2*OUT-1:0] m_q[$];
    logic [2*OUT-1:0] m_hold;
    int               m_hold_n, m_cnt, m_drops;
    bit               m_ovf;
    logic [OUT-1:0]   dut_words[$];
    logic [OUT-1:0]   mdl_words[$];

    function automatic int exp_drop();
`ifdef GAUSS_DROP_CNT_EN
        return (m_drops > 65535) ? 65535 : m_drops;
`else
        return 0;
`endif
    endfunction

    function automatic bit words_match();
        if (dut_words.size() != mdl_words.size()) return 1'b0;
        foreach (mdl_words[i]) if (dut_words[i] !== mdl_words[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_hold = '0; m_hold_n = 0; m_cnt = 0; m_drops = 0; m_ovf = 1'b0;
        dut_words.delete();
        mdl_words.delete();
    endfunction

    // Drives one cycle of inputs, logs DUT handshakes, and advances the reference.
    task automatic step(input logic en, input logic [OUT-1:0] a, input logic [OUT-1:0] b,
                        input logic rdy);
        logic pv; logic [OUT-1:0] pd; bit warm, wr, drp, pop;
        in_en = en; in1 = a; in2 = b; dout_ready = rdy;
        #1;
        pv = dout_valid; pd = dout;
        @(posedge clk);
        if (pv && rdy) dut_words.push_back(pd);
        warm = (m_cnt == WARMUP);
        wr   = warm && en && (m_q.size() < DEPTH);
        drp  = warm && en && (m_q.size() >= DEPTH);
        pop  = (m_q.size() > 0) && (m_hold_n == 0 || (m_hold_n == 1 && rdy));
        if (m_hold_n > 0 && rdy) begin
            mdl_words.push_back(m_hold_n == 2 ? m_hold[2*OUT-1:OUT] : m_hold[OUT-1:0]);
            m_hold_n--;
        end
        if (pop) begin m_hold = m_q.pop_front(); m_hold_n = 2; end
        if (wr) m_q.push_back({a, b});
        if (drp) begin m_ovf = 1'b1; m_drops++; end
        if (m_cnt < WARMUP) m_cnt++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_en = 1'b0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_flags full=%b empty=%b want 0/1", full, empty); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
        do_reset();
    endtask

    task automatic test_warmup();
        do_reset();
        for (int k = 0; k < 12; k++) step(1'b1, OUT'(k), ~OUT'(k), 1'b1);
        repeat (20) step(1'b0, '0, '0, 1'b1);
        checks++;
        if (dut_words.size() < 2 || dut_words[0] !== 32'd4 || dut_words[1] !== ~32'd4) begin
            errors++;
            $display("FAIL warmup_first got %h want 00000004 (n=%0d)",
                     dut_words.size() > 0 ? dut_words[0] : 32'hx, dut_words.size());
        end
        checks++; if (dut_words.size() != 16) begin errors++; $display("FAIL warmup_count got %0d want 16", dut_words.size()); end
        checks++; if (!words_match()) begin errors++; $display("FAIL warmup_seq dut_n=%0d want_n=%0d", dut_words.size(), mdl_words.size()); end
        checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL warmup_drop drop=%0d ovf=%b want 0/0", drop_cnt, overflow); end
    endtask

    task automatic test_single();
        dut_words.delete(); mdl_words.delete();
        step(1'b1, 32'h0000_1234, 32'hFFFF_0001, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 valid=%b want 0", dout_valid); end
        step(1'b0, '0, '0, 1'b1);
        checks++; if (dout_valid !== 1'b1 || dout !== 32'h0000_1234) begin errors++; $display("FAIL single_w1 valid=%b dout=%h want 1/00001234", dout_valid, dout); end
        step(1'b0, '0, '0, 1'b1);
        checks++; if (dout_valid !== 1'b1 || dout !== 32'hFFFF_0001) begin errors++; $display("FAIL single_w2 valid=%b dout=%h want 1/ffff0001", dout_valid, dout); end
        step(1'b0, '0, '0, 1'b1);
        checks++; if (dout_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL single_end valid=%b empty=%b want 0/1", dout_valid, empty); end
        checks++; if (!words_match()) begin errors++; $display("FAIL single_seq dut_n=%0d want_n=%0d", dut_words.size(), mdl_words.size()); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        dut_words.delete(); mdl_words.delete();
        step(1'b1, 32'h0000_1234, 32'hFFFF_0001, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, 1'b0);
            if (dout_valid !== 1'b1 || dout !== 32'h0000_1234) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d want 0 (dout=%h)", bad, dout); end
        repeat (4) step(1'b0, '0, '0, 1'b1);
        checks++;
        if (dut_words.size() != 2 || dut_words[0] !== 32'h0000_1234 || dut_words[1] !== 32'hFFFF_0001) begin
            errors++; $display("FAIL bp_deliver got n=%0d want 2 words 00001234,ffff0001", dut_words.size());
        end
        checks++; if (dout_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL bp_end valid=%b empty=%b want 0/1", dout_valid, empty); end
    endtask

    task automatic test_overflow();
        int want_drop;
        dut_words.delete(); mdl_words.delete();
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, $urandom, 1'b0);
`ifdef GAUSS_DROP_CNT_EN
        want_drop = 3;
`else
        want_drop = 0;
`endif
        checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_level level=%0d full=%b want 16/1", level, full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (drop_cnt !== 16'(want_drop)) begin errors++; $display("FAIL ovf_dropcnt got %0d want %0d", drop_cnt, want_drop); end
        repeat (40) step(1'b0, '0, '0, 1'b1);
        checks++; if (dut_words.size() != 34 || !words_match()) begin errors++; $display("FAIL ovf_drain dut_n=%0d want 34", dut_words.size()); end
        checks++; if (overflow !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL ovf_sticky ovf=%b empty=%b want 1/1", overflow, empty); end
    endtask

    task automatic test_random();
        int pushed = 0, lvl_bad = 0;
        bit en;
        do_reset();
        repeat (WARMUP) step(1'b0, '0, '0, 1'b1);
        for (int c = 0; c < 400 && pushed < 40; c++) begin
            en = ($urandom_range(0, 1) == 1);
            if (en) pushed++;
            step(en, $urandom, $urandom, ($urandom_range(0, 3) != 0));
            if (level !== (AW+1)'(m_q.size()) || overflow !== m_ovf || drop_cnt !== 16'(exp_drop())) lvl_bad++;
        end
        repeat (100) step(1'b0, '0, '0, ($urandom_range(0, 3) != 0));
        checks++; if (pushed != 40) begin errors++; $display("FAIL rand_pushed got %0d want 40", pushed); end
        checks++; if (lvl_bad != 0) begin errors++; $display("FAIL rand_state bad_cycles=%0d want 0", lvl_bad); end
        checks++; if (!words_match()) begin errors++; $display("FAIL rand_seq dut_n=%0d want_n=%0d", dut_words.size(), mdl_words.size()); end
        checks++; if (mdl_words.size() != 2 * (40 - m_drops)) begin errors++; $display("FAIL rand_loss got %0d words want %0d", mdl_words.size(), 2 * (40 - m_drops)); end
        checks++; if (empty !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL rand_end empty=%b valid=%b want 1/0", empty, dout_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (WARMUP) step(1'b0, '0, '0, 1'b0);
        step(1'b1, 32'hAAAA_0001, 32'hBBBB_0001, 1'b0);
        step(1'b1, 32'hCCCC_0002, 32'hDDDD_0002, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        checks++; if (dout_valid !== 1'b1 || dout !== 32'hBBBB_0001 || level !== 5'd1) begin errors++; $display("FAIL ar_pre valid=%b dout=%h level=%0d want 1/bbbb0001/1", dout_valid, dout, level); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dout_valid !== 1'b0 || dout !== '0) begin errors++; $display("FAIL ar_valid valid=%b dout=%h want 0/0", dout_valid, dout); end
        checks++; if (level !== '0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL ar_level level=%0d empty=%b want 0/1", level, empty); end
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 32'h100 + OUT'(k), 32'h200 + OUT'(k), 1'b1);
        repeat (20) step(1'b0, '0, '0, 1'b1);
        checks++; if (dut_words.size() < 1 || dut_words[0] !== 32'h104) begin errors++; $display("FAIL ar_first got %h want 00000104", dut_words.size() > 0 ? dut_words[0] : 32'hx); end
        checks++; if (dut_words.size() != 12 || !words_match()) begin errors++; $display("FAIL ar_seq dut_n=%0d want 12", dut_words.size()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_warmup();
        test_single();
        test_backpressure();
        test_overflow();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
